moving_average2_level_detector: RTL and testbench
=================================================

// Module: moving_average2_level_detector
// PURPOSE
//  Downstream stage of the MovingAverage2 filter: consumes the signed smoothed sample stream.
//  Applies a hysteresis threshold with a consecutive-sample debounce.
//  Produces a registered level flag plus a valid/ready event record for each level change.
//  Feeds the control/event logic.
// PARAMETERS
//  WIDTH      8    sample width, signed two's complement
//  HI_THRESH  32   rise threshold; a sample qualifies high when sample > HI_THRESH (signed, strict)
//  LO_THRESH  -32  fall threshold; a sample qualifies low when sample < LO_THRESH (signed, strict)
//                  LO_THRESH < HI_THRESH is required
//  HOLD       3    consecutive qualifying valid samples needed to switch level; >= 1; counter is clog2(HOLD+1) bits
// PORTS
//  system1000      in   1      clock; all logic on rising edge
//  system1000_rst  in   1      synchronous reset, active-high
//  avg_i           in   WIDTH  signed sample from the moving-average stage
//  avg_valid_i     in   1      avg_i is a new sample this cycle
//  level_o         out  1      debounced level: 1 = high, 0 = low
//  evt_valid_o     out  1      event record pending
//  evt_ready_i     in   1      consumer accepts the event when evt_valid_o & evt_ready_i
//  evt_rise_o      out  1      event direction: 1 = low->high, 0 = high->low
//  ovf_o           out  1      sticky flag: an unaccepted event was overwritten
//  ovf_clr_i       in   1      clears ovf_o
//  peak_o          out  WIDTH  episode peak (present only with LEVEL_DET_PEAK_EN)
// BEHAVIOUR
//  Reset
//   - state=S_LOW, cnt=0, all outputs 0, peak_o=0.
//   - Reset asserted mid-operation discards any pending event and does not set ovf_o.
//  FSM
//   - Advances only on cycles with avg_valid_i=1; cycles with avg_valid_i=0 hold all state.
//   - S_LOW:     qualifying-high sample -> cnt=1; go S_RISING, or go S_HIGH directly if HOLD==1.
//   - S_RISING:  qualifying-high -> cnt+1; when cnt reaches HOLD -> S_HIGH and emit a rise event.
//                Any other valid sample -> S_LOW, cnt=0.
//   - S_HIGH:    qualifying-low sample -> cnt=1; go S_FALLING, or go S_LOW directly if HOLD==1.
//   - S_FALLING: qualifying-low -> cnt+1; when cnt reaches HOLD -> S_LOW and emit a fall event.
//                Any other valid sample -> S_HIGH, cnt=0.
//   - level_o = 1 in S_HIGH and S_FALLING.
//   - Latency: level_o and evt_valid_o change on the edge that samples the HOLD-th qualifying sample.
//   - A sample between the thresholds breaks both debounce runs.
//  Events
//   - evt_valid_o/evt_rise_o are registered and held stable until the handshake completes.
//   - On handshake with no new event: evt_valid_o = 0 on the next cycle.
//   - New event while pending and not accepted this cycle: the newest event overwrites the record; ovf_o <= 1.
//   - New event in the same cycle as a handshake: the new record loads; no overflow.
//   - ovf_clr_i clears ovf_o. If a clear coincides with a new overflow, set wins.
//  Arithmetic
//   - Comparisons are signed WIDTH-bit. Thresholds must be representable in WIDTH bits.
//   - Full-scale -128/127 inputs need no saturation.
// CONFIGURATION
//  LEVEL_DET_PEAK_EN defined
//   - Running max register, signed WIDTH.
//   - Loaded with the first qualifying-high sample in S_LOW.
//   - Updated with max(run, avg_i) on every valid sample while level_o=1 or in S_RISING.
//   - Cleared to 0 when S_RISING aborts.
//   - peak_o loads the running max together with each event record (the rise value, or the episode max on fall).
//   - peak_o is stable while evt_valid_o=1.
//  LEVEL_DET_PEAK_EN undefined
//   - peak_o port and the running max register are absent.
//   - All other behaviour is identical.
// TESTING (WIDTH=8, HI=32, LO=-32, HOLD=3)
//  - Reset: hold system1000_rst 2 cycles with random inputs -> level_o, evt_valid_o, ovf_o all 0.
//  - Valid samples 40,50,60 -> level_o=1 and evt_valid_o=1, evt_rise_o=1 after the 3rd edge.
//    Same run with avg_valid_i=0 gaps between samples -> identical result.
//  - 40,50,10,40,50 -> level_o stays 0, no event; then 60 -> rise event.
//  - From high, samples -40,-50,0,-40,-50,-60 -> fall only after the last three samples;
//    evt_rise_o=0. With PEAK_EN, after rise samples 40,50,60,127,-40,-50,-60 -> peak_o=127.
//  - evt_ready_i=0 through a rise then a fall -> ovf_o=1, record shows the fall.
//    ovf_clr_i pulse -> ovf_o=0. Event plus handshake in the same cycle -> ovf_o stays 0.
//  - Assert system1000_rst while in S_RISING with an event pending -> all outputs 0.
//    Next 40,50,60 requires the full 3-sample run.

Source files
------------

// File: rtl/moving_average2_level_detector_if.sv
// Sample-in / level-and-event-out bundle for moving_average2_level_detector.
// peak_o exists only when LEVEL_DET_PEAK_EN is defined.
interface moving_average2_level_detector_if #(
  parameter int WIDTH = 8
);
  logic signed [WIDTH-1:0] avg_i;
  logic                    avg_valid_i;
  logic                    level_o;
  logic                    evt_valid_o;
  logic                    evt_ready_i;
  logic                    evt_rise_o;
  logic                    ovf_o;
  logic                    ovf_clr_i;
`ifdef LEVEL_DET_PEAK_EN
  logic signed [WIDTH-1:0] peak_o;
`endif

`ifdef LEVEL_DET_PEAK_EN
  modport slave (
    input  avg_i, avg_valid_i, evt_ready_i, ovf_clr_i,
    output level_o, evt_valid_o, evt_rise_o, ovf_o, peak_o
  );
  modport master (
    output avg_i, avg_valid_i, evt_ready_i, ovf_clr_i,
    input  level_o, evt_valid_o, evt_rise_o, ovf_o, peak_o
  );
`else
  modport slave (
    input  avg_i, avg_valid_i, evt_ready_i, ovf_clr_i,
    output level_o, evt_valid_o, evt_rise_o, ovf_o
  );
  modport master (
    output avg_i, avg_valid_i, evt_ready_i, ovf_clr_i,
    input  level_o, evt_valid_o, evt_rise_o, ovf_o
  );
`endif
endinterface

// File: rtl/moving_average2_level_detector.sv
// Hysteresis level detector with consecutive-sample debounce and a one-deep event record.
// Define LEVEL_DET_PEAK_EN to add the episode peak tracker and peak_o.
//   state     | meaning
//   S_LOW     | level low, no high run in progress
//   S_RISING  | level low, counting qualifying-high samples
//   S_HIGH    | level high, no low run in progress
//   S_FALLING | level high, counting qualifying-low samples
module moving_average2_level_detector #(
  parameter int WIDTH     = 8,
  parameter int HI_THRESH = 32,
  parameter int LO_THRESH = -32,
  parameter int HOLD      = 3
) (
  input logic                           system1000,
  input logic                           system1000_rst,
  moving_average2_level_detector_if.slave bus
);
  localparam int CW = $clog2(HOLD + 1);
  localparam logic signed [WIDTH-1:0] HI = WIDTH'(HI_THRESH);
  localparam logic signed [WIDTH-1:0] LO = WIDTH'(LO_THRESH);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

  typedef enum logic [1:0] {S_LOW, S_RISING, S_HIGH, S_FALLING} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    level, evt_valid, evt_rise, ovf;
  logic signed [WIDTH-1:0] sample;
  logic                    qual_hi, qual_lo, handshake, clobber;

  assign sample    = bus.avg_i;
  assign qual_hi   = sample > HI;
  assign qual_lo   = sample < LO;
  assign handshake = evt_valid & bus.evt_ready_i;
  // a new event arriving now would overwrite a record the consumer never took
  assign clobber   = evt_valid & ~bus.evt_ready_i;

  assign bus.level_o     = level;
  assign bus.evt_valid_o = evt_valid;
  assign bus.evt_rise_o  = evt_rise;
  assign bus.ovf_o       = ovf;

`ifdef LEVEL_DET_PEAK_EN
  logic signed [WIDTH-1:0] run, run_max, peak;
  assign run_max    = (sample > run) ? sample : run;
  assign bus.peak_o = peak;
`endif

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state     <= S_LOW;
      cnt       <= '0;
      level     <= 1'b0;
      evt_valid <= 1'b0;
      evt_rise  <= 1'b0;
      ovf       <= 1'b0;
`ifdef LEVEL_DET_PEAK_EN
      run       <= '0;
      peak      <= '0;
`endif
    end else begin
      // later assignments below (new event, overflow set) take priority
      if (bus.ovf_clr_i) ovf <= 1'b0;
      if (handshake) evt_valid <= 1'b0;
      if (bus.avg_valid_i) begin
        case (state)
          S_LOW: begin
            if (qual_hi) begin
`ifdef LEVEL_DET_PEAK_EN
              run <= sample;
`endif
              if (HOLD == 1) begin
                state     <= S_HIGH;
                level     <= 1'b1;
                evt_valid <= 1'b1;
                evt_rise  <= 1'b1;
                if (clobber) ovf <= 1'b1;
`ifdef LEVEL_DET_PEAK_EN
                peak      <= sample;
`endif
              end else begin
                state <= S_RISING;
                cnt   <= CW'(1);
              end
            end
          end
          S_RISING: begin
            if (qual_hi) begin
`ifdef LEVEL_DET_PEAK_EN
              run <= run_max;
`endif
              if (cnt == HOLD_C - 1'b1) begin
                state     <= S_HIGH;
                cnt       <= '0;
                level     <= 1'b1;
                evt_valid <= 1'b1;
                evt_rise  <= 1'b1;
                if (clobber) ovf <= 1'b1;
`ifdef LEVEL_DET_PEAK_EN
                peak      <= run_max;
`endif
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              state <= S_LOW;
              cnt   <= '0;
`ifdef LEVEL_DET_PEAK_EN
              run   <= '0;
`endif
            end
          end
          S_HIGH: begin
`ifdef LEVEL_DET_PEAK_EN
            run <= run_max;
`endif
            if (qual_lo) begin
              if (HOLD == 1) begin
                state     <= S_LOW;
                level     <= 1'b0;
                evt_valid <= 1'b1;
                evt_rise  <= 1'b0;
                if (clobber) ovf <= 1'b1;
`ifdef LEVEL_DET_PEAK_EN
                peak      <= run_max;
`endif
              end else begin
                state <= S_FALLING;
                cnt   <= CW'(1);
              end
            end
          end
          S_FALLING: begin
`ifdef LEVEL_DET_PEAK_EN
            run <= run_max;
`endif
            if (qual_lo) begin
              if (cnt == HOLD_C - 1'b1) begin
                state     <= S_LOW;
                cnt       <= '0;
                level     <= 1'b0;
                evt_valid <= 1'b1;
                evt_rise  <= 1'b0;
                if (clobber) ovf <= 1'b1;
`ifdef LEVEL_DET_PEAK_EN
                peak      <= run_max;
`endif
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              state <= S_HIGH;
              cnt   <= '0;
            end
          end
          default: state <= S_LOW;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_moving_average2_level_detector.sv
// Bench for moving_average2_level_detector: directed spec scenarios plus random traffic
// against a streak-counting reference model.
module tb_moving_average2_level_detector;
  localparam int HI   = 32;
  localparam int LO   = -32;
  localparam int HOLD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  moving_average2_level_detector_if #(.WIDTH(8)) bus ();

  moving_average2_level_detector #(
    .WIDTH(8), .HI_THRESH(HI), .LO_THRESH(LO), .HOLD(HOLD)
  ) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .bus            (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_level, m_streak, m_run, m_evt_valid, m_rise, m_ovf, m_peak;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_streak = 0; m_run = 0;
    m_evt_valid = 0; m_rise = 0; m_ovf = 0; m_peak = 0;
  endtask

  task automatic model_step(input int s, input bit v, input bit rdy, input bit clr, input bit r);
    bit hs, ev, ev_rise;
    if (r) begin
      model_reset();
      return;
    end
    hs = (m_evt_valid != 0) && rdy;
    ev = 0; ev_rise = 0;
    if (v) begin
      if (m_level == 0) begin
        if (s > HI) begin
          m_run = (m_streak == 0) ? s : ((s > m_run) ? s : m_run);
          m_streak++;
          if (m_streak == HOLD) begin
            m_level = 1; m_streak = 0; ev = 1; ev_rise = 1;
          end
        end else begin
          m_streak = 0;
        end
      end else begin
        m_run = (s > m_run) ? s : m_run;
        if (s < LO) begin
          m_streak++;
          if (m_streak == HOLD) begin
            m_level = 0; m_streak = 0; ev = 1; ev_rise = 0;
          end
        end else begin
          m_streak = 0;
        end
      end
    end
    if (ev) begin
      if (m_evt_valid != 0 && !hs) m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_evt_valid = 1; m_rise = ev_rise; m_peak = m_run;
    end else begin
      if (hs) m_evt_valid = 0;
      if (clr) m_ovf = 0;
    end
  endtask

  task automatic compare_all();
    check("level", int'(bus.level_o), m_level);
    check("evt_valid", int'(bus.evt_valid_o), m_evt_valid);
    if (m_evt_valid != 0) check("evt_rise", int'(bus.evt_rise_o), m_rise);
    check("ovf", int'(bus.ovf_o), m_ovf);
`ifdef LEVEL_DET_PEAK_EN
    check("peak", int'(bus.peak_o), m_peak);
`endif
  endtask

  task automatic step(input int s, input bit v, input bit rdy, input bit clr, input bit r);
    bus.avg_i       = 8'(s);
    bus.avg_valid_i = v;
    bus.evt_ready_i = rdy;
    bus.ovf_clr_i   = clr;
    rst             = r;
    @(posedge clk);
    model_step(s, v, rdy, clr, r);
    @(negedge clk);
    compare_all();
  endtask

  task automatic smp(input int s, input bit rdy);
    step(s, 1'b1, rdy, 1'b0, 1'b0);
  endtask

  task automatic idle(input bit rdy);
    step(0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(int'($urandom_range(0, 255)) - 128, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    step(int'($urandom_range(0, 255)) - 128, 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
  endtask

  initial begin
    int mode;
    int s;
    model_reset();
    bus.avg_i = '0; bus.avg_valid_i = 1'b0; bus.evt_ready_i = 1'b0; bus.ovf_clr_i = 1'b0;

    do_reset();
    check("rst_level", int'(bus.level_o), 0);
    check("rst_evt", int'(bus.evt_valid_o), 0);
    check("rst_ovf", int'(bus.ovf_o), 0);

    smp(40, 0); smp(50, 0);
    check("rise_early", int'(bus.level_o), 0);
    smp(60, 0);
    check("rise_level", int'(bus.level_o), 1);
    check("rise_evt", int'(bus.evt_valid_o), 1);
    check("rise_dir", int'(bus.evt_rise_o), 1);
    idle(1);
    check("hs_clear", int'(bus.evt_valid_o), 0);

    do_reset();
    smp(40, 0); idle(0); smp(50, 0); idle(0); idle(0); smp(60, 0);
    check("gap_level", int'(bus.level_o), 1);
    check("gap_evt", int'(bus.evt_rise_o), 1);

    do_reset();
    smp(40, 0); smp(50, 0); smp(10, 0); smp(40, 0); smp(50, 0);
    check("break_level", int'(bus.level_o), 0);
    check("break_evt", int'(bus.evt_valid_o), 0);
    smp(60, 0);
    check("break_rise", int'(bus.level_o), 1);
    idle(1);

    smp(-40, 0); smp(-50, 0); smp(0, 0); smp(-40, 0); smp(-50, 0);
    check("fall_early", int'(bus.level_o), 1);
    smp(-60, 0);
    check("fall_level", int'(bus.level_o), 0);
    check("fall_dir", int'(bus.evt_rise_o), 0);
    idle(1);

`ifdef LEVEL_DET_PEAK_EN
    do_reset();
    smp(40, 1); smp(50, 1); smp(60, 1);
    check("peak_rise", int'(bus.peak_o), 60);
    smp(127, 1); smp(-40, 1); smp(-50, 1); smp(-60, 1);
    check("peak_fall", int'(bus.peak_o), 127);
    idle(1);
`endif

    do_reset();
    smp(40, 0); smp(50, 0); smp(60, 0); smp(-40, 0); smp(-50, 0); smp(-60, 0);
    check("ovf_set", int'(bus.ovf_o), 1);
    check("ovf_rec", int'(bus.evt_rise_o), 0);
    step(0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovf_clr", int'(bus.ovf_o), 0);
    idle(1);
    smp(40, 0); smp(50, 0); smp(60, 0); smp(-40, 0); smp(-50, 0); smp(-60, 1);
    check("same_cyc_ovf", int'(bus.ovf_o), 0);
    check("same_cyc_evt", int'(bus.evt_valid_o), 1);
    check("same_cyc_dir", int'(bus.evt_rise_o), 0);

    smp(40, 0);
    do_reset();
    check("mid_rst_level", int'(bus.level_o), 0);
    check("mid_rst_evt", int'(bus.evt_valid_o), 0);
    check("mid_rst_ovf", int'(bus.ovf_o), 0);
    smp(50, 0); smp(60, 0);
    check("mid_rst_run", int'(bus.level_o), 0);
    smp(70, 0);
    check("mid_rst_rise", int'(bus.level_o), 1);

    mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) mode = int'($urandom_range(0, 2));
      if ($urandom_range(0, 4) != 0) begin
        case (mode)
          0: s = int'($urandom_range(33, 127));
          1: s = -int'($urandom_range(33, 128));
          default: s = int'($urandom_range(0, 255)) - 128;
        endcase
      end else begin
        s = int'($urandom_range(0, 64)) - 32;
      end
      step(s, $urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
